load_store_unit: RTL

Data-side memory access unit for the RV32I core: the responder to the decoder's MemRead/MemWrite/funct3 outputs. Turns each load or store into a single word-aligned bus transaction with byte strobes, stalls the pipeline until the bus completes, and returns the sign- or zero-extended load result. Sits between the execute stage (ALU result as address, rs2 as store data) and the data-memory bus.

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit: one word-aligned bus transaction per access, with byte strobes and load extension.
// Optional bus wait timeout is enabled with `define LSU_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        lsu_err_o,
    output logic [31:0] rdata_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  addr_lo_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        bus_req_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [3:0]  bus_wstrb_q;

    logic        legal_d;
    logic        misalign_d;
    logic        access_ok_d;
    logic [3:0]  st_wstrb_d;
    logic [31:0] st_wdata_d;
    logic [31:0] lane_d;
    logic [31:0] load_d;
    logic        timeout_hit;

    // mem_read wins when both requests are high, so legality follows the read table then.
    always_comb begin
        legal_d = 1'b0;
        if (mem_read_i) begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_d = 1'b1;
                default:                                legal_d = 1'b0;
            endcase
        end else begin
            case (funct3_i)
                3'b000, 3'b001, 3'b010: legal_d = 1'b1;
                default:                legal_d = 1'b0;
            endcase
        end
        misalign_d  = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        access_ok_d = legal_d && !misalign_d;
    end

    always_comb begin
        st_wstrb_d = 4'b1111;
        st_wdata_d = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                st_wstrb_d = 4'b0001 << addr_i[1:0];
                st_wdata_d = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                st_wstrb_d = 4'b0011 << addr_i[1:0];
                st_wdata_d = {2{wdata_i[15:0]}};
            end
            default: begin
                st_wstrb_d = 4'b1111;
                st_wdata_d = wdata_i;
            end
        endcase
    end

    always_comb begin
        lane_d = bus_rdata_i >> {addr_lo_q, 3'b000};
        case (funct3_q)
            3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
            3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
            3'b100:  load_d = {24'b0, lane_d[7:0]};
            3'b101:  load_d = {16'b0, lane_d[15:0]};
            default: load_d = lane_d;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;

    assign timeout_hit = ((state_q == REQ) || (state_q == RESP)) &&
                         (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if ((state_q == REQ) || (state_q == RESP)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            funct3_q    <= 3'b000;
            addr_lo_q   <= 2'b00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'h0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_wdata_q <= 32'h0;
            bus_wstrb_q <= 4'b0000;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read_i || mem_write_i) begin
                        funct3_q  <= funct3_i;
                        addr_lo_q <= addr_i[1:0];
                        if (access_ok_d) begin
                            state_q     <= REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= !mem_read_i;
                            bus_addr_q  <= {addr_i[31:2], 2'b00};
                            bus_wdata_q <= st_wdata_d;
                            bus_wstrb_q <= mem_read_i ? 4'b0000 : st_wstrb_d;
                        end else begin
                            // Rejected accesses never touch the bus registers.
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_q <= 1'b0;
                        if (bus_we_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RESP;
                        end
                    end else if (timeout_hit) begin
                        bus_req_q <= 1'b0;
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                        rdata_q   <= 32'h0;
                    end
                end
                RESP: begin
                    if (bus_rvalid_i) begin
                        rdata_q <= load_d;
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (timeout_hit) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall_o     = ((state_q == IDLE) && (mem_read_i || mem_write_i)) ||
                         (state_q == REQ) || (state_q == RESP);
    assign done_o      = done_q;
    assign lsu_err_o   = err_q;
    assign rdata_o     = rdata_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_wstrb_o = bus_wstrb_q;

endmodule
